// File: rtl/ps2_host.sv
// ps2_host - PS/2 host link layer on shared open-drain pads.
// Glitch-filtered receive with parity/stop check, inhibit/request-to-send
// transmit with device ack, and a mid-frame timeout.
// Optional: define PS2_LED_EN to build the LED sequencer (ED, <leds>) on the TX path.
module ps2_host #(
    parameter int FILTER  = 8,
    parameter int INHIBIT = 400,
    parameter int TIMEOUT = 8000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       clk_oe,
    output logic       dat_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic [2:0] leds
);
    localparam int TMAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_INH, ST_RTS, ST_TX, ST_ACK, ST_WREL} state_t;
    state_t state, state_n;

    logic [FILTER-1:0] clk_sh, dat_sh, clk_sh_n, dat_sh_n;
    logic              clk_f, dat_f, clk_lvl, dat_lvl;
    logic              ev, wrel_ok, tmo, tx_go;
    logic [TW-1:0]     tmr;
    logic [3:0]        bcnt;
    logic [7:0]        sr, tx_byte, tx_src;
    logic              par, ack;

    assign clk_sh_n = {clk_sh[FILTER-2:0], ps2_clk};
    assign dat_sh_n = {dat_sh[FILTER-2:0], ps2_dat};

    // Level after this ce: changes only when the whole sample window agrees
    always_comb begin
        clk_lvl = clk_f;
        dat_lvl = dat_f;
        if (&clk_sh_n)       clk_lvl = 1'b1;
        else if (~|clk_sh_n) clk_lvl = 1'b0;
        if (&dat_sh_n)       dat_lvl = 1'b1;
        else if (~|dat_sh_n) dat_lvl = 1'b0;
    end

    // Falling edge of the filtered clock; data is taken from the filtered level at the same tick
    assign ev      = ce & clk_f & ~clk_lvl;
    assign wrel_ok = ce & clk_lvl & dat_lvl;

`ifdef PS2_LED_EN
    typedef enum logic [2:0] {P_IDLE, P_ED, P_FA1, P_VGO, P_VAL, P_FA2} phase_t;
    phase_t        phase;
    logic [2:0]    led_sent, led_pend;
    logic [TW-1:0] wait_t;
    logic          seq_go;

    assign seq_go  = ce && state == ST_IDLE &&
                     ((phase == P_IDLE && leds != led_sent) || phase == P_VGO);
    assign tx_busy = (state != ST_IDLE) || (phase != P_IDLE);
    assign tx_go   = seq_go || (ce && state == ST_IDLE && tx_start && !tx_busy);
    assign tx_src  = !seq_go ? tx_data : (phase == P_VGO) ? {5'b0, leds} : 8'hED;

    // LED sequencer: ED, await FA, value, await FA; anything else drops back and retries
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase    <= P_IDLE;
            led_sent <= 3'b000;
            led_pend <= 3'b000;
            wait_t   <= '0;
        end else begin
            case (phase)
                P_IDLE: if (seq_go) phase <= P_ED;
                P_ED, P_VAL: begin
                    wait_t <= '0;
                    if (tx_done) phase <= tx_error ? P_IDLE : (phase == P_ED) ? P_FA1 : P_FA2;
                end
                P_FA1, P_FA2: begin
                    if (ce && state == ST_IDLE) wait_t <= wait_t + 1'b1;
                    if (rx_valid && rx_data == 8'hFA) begin
                        phase <= (phase == P_FA1) ? P_VGO : P_IDLE;
                        if (phase == P_FA2) led_sent <= led_pend;
                    end else if (rx_valid || rx_error || wait_t == TW'(TIMEOUT - 1)) begin
                        phase <= P_IDLE;
                    end
                end
                P_VGO: if (seq_go) begin
                    phase    <= P_VAL;
                    led_pend <= leds;
                end
                default: phase <= P_IDLE;
            endcase
        end
    end
`else
    logic unused_leds;
    assign unused_leds = ^leds;
    assign tx_busy     = (state != ST_IDLE);
    assign tx_go       = ce && state == ST_IDLE && tx_start;
    assign tx_src      = tx_data;
`endif

    // Pad sample windows and filtered levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sh <= '1;
            dat_sh <= '1;
            clk_f  <= 1'b1;
            dat_f  <= 1'b1;
        end else if (ce) begin
            clk_sh <= clk_sh_n;
            dat_sh <= dat_sh_n;
            clk_f  <= clk_lvl;
            dat_f  <= dat_lvl;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state; a transmit request wins over a receive start in IDLE
    always_comb begin
        state_n = state;
        tmo     = 1'b0;
        case (state)
            ST_IDLE: if (tx_go) state_n = ST_INH;
                     else if (ev && !dat_lvl) state_n = ST_RX;
            ST_RX:   if (ev && bcnt == 4'd9) state_n = ST_IDLE;
            ST_INH:  if (ce && tmr == TW'(INHIBIT - 1)) state_n = ST_RTS;
            ST_RTS:  if (ev) state_n = ST_TX;
            ST_TX:   if (ev && bcnt == 4'd9) state_n = ST_ACK;
            ST_ACK:  if (ev) state_n = ST_WREL;
            ST_WREL: if (wrel_ok) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (ce && !ev && tmr == TW'(TIMEOUT - 1) && state != ST_IDLE && state != ST_INH &&
            !(state == ST_WREL && wrel_ok)) begin
            tmo     = 1'b1;
            state_n = ST_IDLE;
        end
    end

    // Datapath: shifters, tick timer, pad drives and result pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            tmr      <= '0;
            bcnt     <= '0;
            sr       <= 8'h00;
            tx_byte  <= 8'h00;
            par      <= 1'b0;
            ack      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (ce) begin
                // our own inhibit pulls the clock low, so events there must not restart the count
                if (state_n != state || (ev && state != ST_INH)) tmr <= '0;
                else if (tmr != TW'(TMAX))                        tmr <= tmr + 1'b1;
                case (state)
                    ST_IDLE: if (tx_go) begin
                        tx_byte <= tx_src;
                        clk_oe  <= 1'b1;
                    end else if (ev && !dat_lvl) begin
                        bcnt <= '0;
                    end
                    ST_RX: if (ev) begin
                        bcnt <= bcnt + 4'd1;
                        if (bcnt < 4'd8)       sr  <= {dat_lvl, sr[7:1]};
                        else if (bcnt == 4'd8) par <= dat_lvl;
                        else if (dat_lvl && ^{sr, par}) begin
                            rx_data  <= sr;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                    ST_INH: if (state_n == ST_RTS) begin
                        clk_oe <= 1'b0;
                        dat_oe <= 1'b1;
                        bcnt   <= '0;
                    end
                    ST_RTS, ST_TX: if (ev) begin
                        bcnt <= bcnt + 4'd1;
                        if (bcnt < 4'd8)       dat_oe <= ~tx_byte[bcnt[2:0]];
                        else if (bcnt == 4'd8) dat_oe <= ^tx_byte;  // odd parity bit is ~^byte
                        else                   dat_oe <= 1'b0;
                    end
                    ST_ACK: if (ev) ack <= ~dat_lvl;
                    ST_WREL: if (wrel_ok) begin
                        tx_done  <= 1'b1;
                        tx_error <= ~ack;
                    end
                    default: ;
                endcase
                if (tmo) begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    if (state == ST_RX) rx_error <= 1'b1;
                    else begin
                        tx_done  <= 1'b1;
                        tx_error <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host - device model on wired-AND pads, random ce, randomized frames
// scored against frame rules computed from bytes with $countones.
module tb_ps2_host;
    localparam int HP = 60;  // device half clock period in system clocks

    logic       clock = 1'b0, reset = 1'b0, ce = 1'b0;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       ps2_clk, ps2_dat, clk_oe, dat_oe;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       rx_valid, rx_error, tx_busy, tx_done, tx_error;
    logic       tx_start = 1'b0;
    logic [2:0] leds = 3'b000;
    bit         ce_off = 1'b0;

    int checks = 0, errors = 0;
    int n_rxv = 0, n_rxe = 0, n_txd = 0, inh_ticks = 0, rts_ticks = 0, oe_cycles = 0, rel_cnt = 0;
    logic       last_txe = 1'b0, prev_coe = 1'b0;

    ps2_host dut (
        .clock(clock), .reset(reset), .ce(ce), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .clk_oe(clk_oe), .dat_oe(dat_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_error(tx_error), .leds(leds)
    );

    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~dat_oe;

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        #1;
        ce = ce_off ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Event counters sampled mid-cycle; ce/oe here are what the next edge will see
    always @(negedge clock) begin
        if (rx_valid) n_rxv++;
        if (rx_error) n_rxe++;
        if (tx_done) begin n_txd++; last_txe = tx_error; end
        if (ce && clk_oe) inh_ticks++;
        if (ce && dat_oe && !clk_oe) rts_ticks++;
        if (clk_oe) oe_cycles++;
        if (prev_coe && !clk_oe && dat_oe) rel_cnt++;
        prev_coe = clk_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // 11-bit frame, bit 0 first: start, d0..d7, odd parity, stop
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ($countones(b) % 2 == 0);
        return {~bad_stop, p ^ bad_par, b, 1'b0};
    endfunction

    task automatic dev_send(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_dat = frame[i];
            tick(HP);
            dev_clk = 1'b0;
            tick(HP);
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        tick(2 * HP);
    endtask

    // Device side of a host transmit: wait for RTS, clock 11 pulses, collect d0..d7,parity,stop
    task automatic dev_recv(input bit do_ack, output logic [9:0] bits, output bit ok);
        int n;
        n = 0; bits = '0; ok = 1'b0;
        while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && n < 5000) begin tick(1); n++; end
        if (n >= 5000) return;
        ok = 1'b1;
        tick(HP);
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            tick(HP);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_dat;
            if (i == 9 && do_ack) dev_dat = 1'b0;
            if (i == 10) dev_dat = 1'b1;
            tick(HP);
        end
        tick(HP);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(5);
        checks++;
        if ({clk_oe, dat_oe, rx_data, rx_valid, rx_error, tx_busy, tx_done, tx_error} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {clk_oe, dat_oe, rx_data, rx_valid, rx_error, tx_busy, tx_done, tx_error});
        end
        reset = 1'b1;
        tick(20);
        checks++;
        if (n_rxv + n_rxe + n_txd != 0) begin
            errors++; $display("FAIL reset_no_pulse got %0d want 0", n_rxv + n_rxe + n_txd);
        end
    endtask

    task automatic test_rx_fixed();
        int bv, be;
        bv = n_rxv; be = n_rxe;
        dev_send(mk_frame(8'h1C, 0, 0), 11);
        checks++;
        if (n_rxv - bv != 1 || n_rxe - be != 0 || rx_data !== 8'h1C) begin
            errors++; $display("FAIL rx_1c got v=%0d e=%0d d=%h want v=1 e=0 d=1c", n_rxv - bv, n_rxe - be, rx_data);
        end
        bv = n_rxv; be = n_rxe;
        dev_send(mk_frame(8'h1C, 1, 0), 11);
        checks++;
        if (n_rxv - bv != 0 || n_rxe - be != 1 || rx_data !== 8'h1C) begin
            errors++; $display("FAIL rx_badpar got v=%0d e=%0d d=%h want v=0 e=1 d=1c", n_rxv - bv, n_rxe - be, rx_data);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0]  b, exp_last;
        logic [10:0] f;
        int          kind, bv, be;
        bit          good;
        exp_last = rx_data === 8'h1C ? 8'h1C : 8'hxx;
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 3);
            f    = mk_frame(b, kind == 0, kind == 1);
            good = ($countones(f[9:1]) % 2 == 1) && f[10];
            if (good) exp_last = b;
            bv = n_rxv; be = n_rxe;
            dev_send(f, 11);
            checks++;
            if (n_rxv - bv != int'(good) || n_rxe - be != int'(!good) || rx_data !== exp_last) begin
                errors++;
                $display("FAIL rx_rand%0d got v=%0d e=%0d d=%h want v=%0d e=%0d d=%h",
                         k, n_rxv - bv, n_rxe - be, rx_data, good, !good, exp_last);
            end
        end
    endtask

    task automatic test_rx_timeout();
        int bv, be, n;
        bv = n_rxv; be = n_rxe; n = 0;
        dev_send(mk_frame(8'h33, 0, 0), 5);
        while (n_rxe == be && n < 20000) begin tick(1); n++; end
        checks++;
        if (n_rxe - be != 1 || n_rxv - bv != 0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL rx_timeout got e=%0d v=%0d busy=%b want e=1 v=0 busy=0", n_rxe - be, n_rxv - bv, tx_busy);
        end
    endtask

    // One host transmit against the device model; poke=1 also fires a tx_start while busy
    task automatic do_tx(input logic [7:0] b, input bit do_ack, input bit poke, input bit chk_inh);
        logic [10:0] f;
        logic [9:0]  bits;
        bit          ok;
        int          bi, bd, br, bo, n;
        f = mk_frame(b, 0, 0);
        bi = inh_ticks; bd = n_txd; br = rel_cnt; n = 0;
        tx_data = b; tx_start = 1'b1;
        while (!tx_busy && n < 100) begin tick(1); n++; end
        tx_start = 1'b0;
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_accept got busy=%b want 1", tx_busy); end
        if (poke) begin
            tick(20); tx_data = ~b; tx_start = 1'b1; tick(10); tx_start = 1'b0; tx_data = b;
        end
        dev_recv(do_ack, bits, ok);
        checks++;
        if (!ok || bits !== f[10:1]) begin
            errors++; $display("FAIL tx_bits ok=%0d got %b want %b", ok, bits, f[10:1]);
        end
        if (chk_inh) begin
            checks++;
            if (inh_ticks - bi != 400 || rel_cnt - br != 1) begin
                errors++; $display("FAIL tx_inhibit got ticks=%0d rel=%0d want 400 1", inh_ticks - bi, rel_cnt - br);
            end
        end
        n = 0;
        while (n_txd == bd && n < 2000) begin tick(1); n++; end
        checks++;
        if (n_txd - bd != 1 || last_txe !== ~do_ack || tx_busy !== 1'b0 || {clk_oe, dat_oe} !== 2'b00) begin
            errors++;
            $display("FAIL tx_done got n=%0d err=%b busy=%b oe=%b%b want 1 %b 0 00",
                     n_txd - bd, last_txe, tx_busy, clk_oe, dat_oe, ~do_ack);
        end
        if (poke) begin
            bo = oe_cycles;
            tick(300);
            checks++;
            if (oe_cycles != bo || n_txd - bd != 1) begin
                errors++; $display("FAIL tx_busy_ignore got oe=%0d done=%0d want 0 1", oe_cycles - bo, n_txd - bd);
            end
        end
    endtask

    task automatic test_tx_ed();
        do_tx(8'hED, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_tx_random();
        for (int k = 0; k < 3; k++)
            do_tx(8'($urandom), bit'($urandom_range(0, 1)), k == 0, 1'b0);
    endtask

    task automatic test_tx_timeout();
        int br, bd, n;
        br = rts_ticks; bd = n_txd; n = 0;
        tx_data = 8'($urandom); tx_start = 1'b1;
        while (!tx_busy && n < 100) begin tick(1); n++; end
        tx_start = 1'b0;
        n = 0;
        while (n_txd == bd && n < 20000) begin tick(1); n++; end
        checks++;
        if (n_txd - bd != 1 || last_txe !== 1'b1 || {clk_oe, dat_oe} !== 2'b00 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL tx_timeout got n=%0d err=%b oe=%b%b busy=%b want 1 1 00 0",
                               n_txd - bd, last_txe, clk_oe, dat_oe, tx_busy);
        end
        checks++;
        if (rts_ticks - br != 8000) begin
            errors++; $display("FAIL tx_timeout_ticks got %0d want 8000", rts_ticks - br);
        end
    endtask

    task automatic test_reset_midframe();
        int bv, be, bd;
        dev_send(mk_frame(8'h5A, 0, 0), 4);
        reset = 1'b0;
        tick(3);
        checks++;
        if ({clk_oe, dat_oe, rx_data, rx_valid, rx_error, tx_busy, tx_done, tx_error} !== 14'h0) begin
            errors++; $display("FAIL midreset_outputs got %b want 0",
                               {clk_oe, dat_oe, rx_data, rx_valid, rx_error, tx_busy, tx_done, tx_error});
        end
        bv = n_rxv; be = n_rxe; bd = n_txd;
        reset = 1'b1;
        tick(100);
        checks++;
        if (n_rxv != bv || n_rxe != be || n_txd != bd) begin
            errors++; $display("FAIL midreset_pulses got %0d want 0", (n_rxv - bv) + (n_rxe - be) + (n_txd - bd));
        end
        dev_send(mk_frame(8'h5A, 0, 0), 11);
        checks++;
        if (n_rxv - bv != 1 || rx_data !== 8'h5A) begin
            errors++; $display("FAIL midreset_5a got v=%0d d=%h want 1 5a", n_rxv - bv, rx_data);
        end
    endtask

    task automatic test_ce_hold();
        int bv, be;
        ce_off = 1'b1;
        tick(3);
        bv = n_rxv; be = n_rxe;
        dev_send(mk_frame(8'($urandom), 0, 0), 11);
        tx_start = 1'b1; tick(20); tx_start = 1'b0;
        checks++;
        if (n_rxv != bv || n_rxe != be || tx_busy !== 1'b0 || clk_oe !== 1'b0) begin
            errors++; $display("FAIL ce_hold got v=%0d e=%0d busy=%b coe=%b want 0 0 0 0",
                               n_rxv - bv, n_rxe - be, tx_busy, clk_oe);
        end
        ce_off = 1'b0;
        tick(100);
        checks++;
        if (n_rxv != bv || n_rxe != be || tx_busy !== 1'b0) begin
            errors++; $display("FAIL ce_resume got v=%0d e=%0d busy=%b want 0 0 0", n_rxv - bv, n_rxe - be, tx_busy);
        end
    endtask

    task automatic test_leds();
        int bo, bv;
        bo = oe_cycles; bv = n_rxv;
`ifdef PS2_LED_EN
        begin
            logic [9:0]  bits;
            logic [10:0] f;
            bit          ok;
            leds = 3'b100;
            dev_recv(1'b1, bits, ok);
            f = mk_frame(8'hED, 0, 0);
            checks++;
            if (!ok || bits !== f[10:1]) begin errors++; $display("FAIL led_ed got %b want %b", bits, f[10:1]); end
            dev_send(mk_frame(8'hFA, 0, 0), 11);
            dev_recv(1'b1, bits, ok);
            f = mk_frame(8'h04, 0, 0);
            checks++;
            if (!ok || bits !== f[10:1]) begin errors++; $display("FAIL led_val got %b want %b", bits, f[10:1]); end
            dev_send(mk_frame(8'hFA, 0, 0), 11);
            bo = oe_cycles;
            tick(1000);
            checks++;
            if (oe_cycles != bo || n_rxv - bv != 2 || tx_busy !== 1'b0) begin
                errors++; $display("FAIL led_done got oe=%0d v=%0d busy=%b want 0 2 0", oe_cycles - bo, n_rxv - bv, tx_busy);
            end
        end
`else
        leds = 3'b100;
        tick(1000);
        checks++;
        if (oe_cycles != bo || tx_busy !== 1'b0 || n_rxv != bv) begin
            errors++; $display("FAIL led_off got oe=%0d busy=%b want 0 0", oe_cycles - bo, tx_busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rx_fixed();
        test_rx_random();
        test_rx_timeout();
        test_tx_ed();
        test_tx_random();
        test_tx_timeout();
        test_reset_midframe();
        test_ce_hold();
        test_leds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
